// File: rtl/painterengine_gpu_blend_stage_pkg.sv
// Shared definitions for the GPU blend stage.
//   - state_e     : control FSM encoding (IDLE, RUN, DRAIN, DONE, ERROR)
//   - MODE_*      : blend operation select carried on the 2-bit mode input
//   - CH_*        : ARGB8888 channel geometry (8-bit channels, alpha on top)
//   - PROD_W      : width of the per-channel stage-1 product
package painterengine_gpu_blend_stage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [1:0] MODE_COPY  = 2'b00;
  localparam logic [1:0] MODE_BLEND = 2'b01;
  localparam logic [1:0] MODE_ADD   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam int TIMEOUT_DEFAULT = 256;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 8;
  localparam int CH_B_LSB = 0;
  localparam int CH_G_LSB = 8;
  localparam int CH_R_LSB = 16;
  localparam int CH_A_LSB = 24;

  // Largest blend product is 255*255 + 128, which fits in 16 bits.
  localparam int PROD_W = 16;

endpackage

// File: rtl/painterengine_gpu_blend_channel.sv
// Combinational 8-bit channel combiner, split around the stage-1 register.
//   mode_i : operation (copy / blend / saturating add)
//   s_i    : source channel, d_i : destination channel, a_i : source alpha
//   prod_o : un-normalised product, registered by the parent in stage 1
//   prod_i : registered product coming back from stage 1
//   c_o    : normalised 8-bit result, registered by the parent in stage 2
// For the alpha channel the source term is a*255, so the blended alpha is
// a + round(d*(255-a)/255) through the same rounding path as colour channels.
module painterengine_gpu_blend_channel
  import painterengine_gpu_blend_stage_pkg::*;
#(
  parameter bit IS_ALPHA = 1'b0
) (
  input  logic [1:0]        mode_i,
  input  logic [CH_W-1:0]   s_i,
  input  logic [CH_W-1:0]   d_i,
  input  logic [CH_W-1:0]   a_i,
  output logic [PROD_W-1:0] prod_o,
  input  logic [PROD_W-1:0] prod_i,
  output logic [CH_W-1:0]   c_o
);

  logic [PROD_W-1:0] s_w;
  logic [PROD_W-1:0] d_w;
  logic [PROD_W-1:0] a_w;
  logic [PROD_W-1:0] inv_a_w;

  assign s_w     = IS_ALPHA ? PROD_W'(255) : PROD_W'(s_i);
  assign d_w     = PROD_W'(d_i);
  assign a_w     = PROD_W'(a_i);
  assign inv_a_w = PROD_W'(255) - a_w;

  // Stage-1 side: products before normalisation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    prod_o = '0;
    case (mode_i)
      MODE_COPY:  prod_o = PROD_W'(s_i);
      MODE_BLEND: prod_o = s_w * a_w + d_w * inv_a_w + PROD_W'(128);
      MODE_ADD:   prod_o = PROD_W'(s_i) + PROD_W'(d_i);
      default:    prod_o = '0;
    endcase
  end

  // Stage-2 side: (t + (t >> 8)) >> 8 with t already carrying the +128 bias
  // is an exactly rounded divide by 255 over the whole product range.
  always_comb begin
    c_o = '0;
    case (mode_i)
      MODE_COPY:  c_o = prod_i[CH_W-1:0];
      MODE_BLEND: c_o = CH_W'((prod_i + (prod_i >> 8)) >> 8);
      MODE_ADD:   c_o = prod_i[CH_W] ? '1 : prod_i[CH_W-1:0];
      default:    c_o = '0;
    endcase
  end

endmodule

// File: rtl/painterengine_gpu_blend_stage.sv
// GPU blend stage: joins a source and a destination ARGB8888 stream pixel by
// pixel, combines them (copy / alpha blend / saturating add) through a
// two-stage pipeline and emits the result toward the DMA writer.
//   i_wire_clock, i_wire_reset      : clock, synchronous active-high reset
//   i_wire_start/length/mode        : job launch (accepted in IDLE/DONE/ERROR)
//   i_wire_src_* / o_wire_src_next  : source stream (data/valid/next)
//   i_wire_dst_* / o_wire_dst_next  : destination stream (data/valid/next)
//   o_wire_data/_valid, i_wire_data_next : result stream
//   o_wire_done, o_wire_error       : sticky status until the next start
module painterengine_gpu_blend_stage
  import painterengine_gpu_blend_stage_pkg::*;
#(
  parameter int LENGTH_WIDTH = 32,
  parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic                    i_wire_clock,
  input  logic                    i_wire_reset,
  input  logic                    i_wire_start,
  input  logic [LENGTH_WIDTH-1:0] i_wire_length,
  input  logic [1:0]              i_wire_mode,
  input  logic [31:0]             i_wire_src_data,
  input  logic                    i_wire_src_valid,
  output logic                    o_wire_src_next,
  input  logic [31:0]             i_wire_dst_data,
  input  logic                    i_wire_dst_valid,
  output logic                    o_wire_dst_next,
  output logic [31:0]             o_wire_data,
  output logic                    o_wire_data_valid,
  input  logic                    i_wire_data_next,
  output logic                    o_wire_done,
  output logic                    o_wire_error
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;
  logic [1:0]              mode_q, mode_d;
  logic [LENGTH_WIDTH-1:0] issued_q, issued_d;
  logic [LENGTH_WIDTH-1:0] retired_q, retired_d;
  logic [STALL_W-1:0]      stall_q, stall_d;
  logic                    flush;

  logic                    s1_valid_q;
  logic [PROD_W-1:0]       s1_prod_q [NUM_CH];
  logic                    out_valid_q;
  logic [31:0]             out_data_q;

  logic [PROD_W-1:0]       prod_w [NUM_CH];
  logic [31:0]             norm_w;

  logic advance, accept, in_ready, join_fire, retire, stalled;

  // Stage 2 moves when it is empty or its beat is being taken; stage 1 can
  // take a new pixel when it is empty or is about to move into stage 2.
  assign advance   = !out_valid_q || i_wire_data_next;
  assign accept    = !s1_valid_q || advance;
  assign in_ready  = accept && (state_q == ST_RUN) && (issued_q < length_q);
  assign join_fire = in_ready && i_wire_src_valid && i_wire_dst_valid;
  assign retire    = out_valid_q && i_wire_data_next;
  assign stalled   = !join_fire && !retire;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    painterengine_gpu_blend_channel #(
      .IS_ALPHA(ch * CH_W == CH_A_LSB)
    ) u_channel (
      .mode_i (mode_q),
      .s_i    (i_wire_src_data[ch*CH_W +: CH_W]),
      .d_i    (i_wire_dst_data[ch*CH_W +: CH_W]),
      .a_i    (i_wire_src_data[CH_A_LSB +: CH_W]),
      .prod_o (prod_w[ch]),
      .prod_i (s1_prod_q[ch]),
      .c_o    (norm_w[ch*CH_W +: CH_W])
    );
  end

  // Control: job launch, pixel accounting and stall watchdog.
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    mode_d    = mode_q;
    issued_d  = issued_q + LENGTH_WIDTH'(join_fire);
    retired_d = retired_q + LENGTH_WIDTH'(retire);
    stall_d   = stall_q;
    flush     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_wire_start) begin
          length_d  = i_wire_length;
          mode_d    = i_wire_mode;
          issued_d  = '0;
          retired_d = '0;
          stall_d   = '0;
          if (i_wire_length == '0 || i_wire_mode == MODE_RSVD) state_d = ST_ERROR;
          else                                                 state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        stall_d = stalled ? stall_q + STALL_W'(1) : '0;
        if (stalled && stall_q == STALL_W'(TIMEOUT - 1)) begin
          // Timeout discards whatever is still in the pipeline.
          state_d = ST_ERROR;
          flush   = 1'b1;
        end else if (state_q == ST_RUN && issued_q == length_q) begin
          state_d = ST_DRAIN;
        end else if (state_q == ST_DRAIN && retired_q == length_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    if (i_wire_reset) begin
      state_q   <= ST_IDLE;
      length_q  <= '0;
      mode_q    <= MODE_COPY;
      issued_q  <= '0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      mode_q    <= mode_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  // Datapath pipeline. Stage 1 holds products, stage 2 the output pixel.
  always_ff @(posedge i_wire_clock) begin
    // NOTE: the pipeline data registers are reset as well so o_wire_data reads
    // zero out of reset; there are no memories here to exclude from reset.
    if (i_wire_reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) s1_prod_q[ch] <= '0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= join_fire;
        for (int ch = 0; ch < NUM_CH; ch++) s1_prod_q[ch] <= prod_w[ch];
      end
      if (advance) begin
        out_valid_q <= s1_valid_q;
        out_data_q  <= norm_w;
      end
    end
  end

  assign o_wire_src_next   = in_ready;
  assign o_wire_dst_next   = in_ready;
  assign o_wire_data       = out_data_q;
  assign o_wire_data_valid = out_valid_q;
  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_painterengine_gpu_blend_stage.sv
// Self-checking bench for painterengine_gpu_blend_stage. Expected pixels are
// pushed to a scoreboard queue on every join and popped on every output beat.
module tb_painterengine_gpu_blend_stage;

  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          i_reset, i_start;
  logic [LW-1:0] i_length;
  logic [1:0]    i_mode;
  logic [31:0]   i_src_data, i_dst_data;
  logic          i_src_valid, i_dst_valid, i_data_next;
  logic          o_src_next, o_dst_next, o_valid, o_done, o_error;
  logic [31:0]   o_data;

  always #5 clk = ~clk;

  painterengine_gpu_blend_stage #(.LENGTH_WIDTH(LW), .TIMEOUT(256)) dut (
    .i_wire_clock      (clk),
    .i_wire_reset      (i_reset),
    .i_wire_start      (i_start),
    .i_wire_length     (i_length),
    .i_wire_mode       (i_mode),
    .i_wire_src_data   (i_src_data),
    .i_wire_src_valid  (i_src_valid),
    .o_wire_src_next   (o_src_next),
    .i_wire_dst_data   (i_dst_data),
    .i_wire_dst_valid  (i_dst_valid),
    .o_wire_dst_next   (o_dst_next),
    .o_wire_data       (o_data),
    .o_wire_data_valid (o_valid),
    .i_wire_data_next  (i_data_next),
    .o_wire_done       (o_done),
    .o_wire_error      (o_error)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  cur_mode;
  int          cyc = 0;
  int          beats, joins, first_join_cyc, first_valid_cyc;
  logic        join_now;
  logic        hold_pending = 1'b0;
  logic [31:0] held_data, last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: rounded divide by 255 written as plain integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] d,
                                        input logic [1:0] m);
    logic [31:0] r;
    int a, sc, dc, res;
    r = '0;
    a = int'(s[31:24]);
    for (int ch = 0; ch < 4; ch++) begin
      sc = int'(s[ch*8 +: 8]);
      dc = int'(d[ch*8 +: 8]);
      case (m)
        2'b00: res = sc;
        2'b01: res = (ch == 3) ? a + (dc * (255 - a) + 127) / 255
                               : (sc * a + dc * (255 - a) + 127) / 255;
        2'b10: res = (sc + dc > 255) ? 255 : sc + dc;
        default: res = 0;
      endcase
      r[ch*8 +: 8] = 8'(res);
    end
    return r;
  endfunction

  // One clock cycle: observe handshakes that will fire at the coming edge,
  // update the scoreboard, then cross the edge and settle.
  task automatic step();
    logic [31:0] e;
    #1;
    check("next_pair", 32'(o_src_next), 32'(o_dst_next));
    join_now = i_src_valid && i_dst_valid && o_src_next;
    if (join_now) begin
      exp_q.push_back(model(i_src_data, i_dst_data, cur_mode));
      joins++;
      if (first_join_cyc < 0) first_join_cyc = cyc;
    end
    if (hold_pending) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data", o_data, held_data);
    end
    hold_pending = o_valid && !i_data_next;
    held_data    = o_data;
    if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_valid && i_data_next) begin
      beats++;
      last_out = o_data;
      check("sb_beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pixel", o_data, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_job(input logic [1:0] mode, input logic [LW-1:0] len);
    beats = 0; joins = 0; first_join_cyc = -1; first_valid_cyc = -1;
    exp_q.delete();
    cur_mode = mode;
    i_mode   = mode;
    i_length = len;
    i_start  = 1'b1;
    step();
    i_start  = 1'b0;
  endtask

  // Runs a job to completion with both inputs always valid. Optional fixed
  // pixels and a downstream stall window after a given number of beats.
  task automatic run_burst(input logic [1:0] mode, input int len, input bit use_fix,
                           input logic [31:0] fs, input logic [31:0] fd,
                           input int stall_after, input int stall_cycles);
    int n, stalls;
    start_job(mode, LW'(len));
    i_src_valid = 1'b1;
    i_dst_valid = 1'b1;
    i_src_data  = use_fix ? fs : $urandom;
    i_dst_data  = use_fix ? fd : $urandom;
    n = 0; stalls = 0;
    while (!o_done && !o_error && n < 2000) begin
      i_data_next = 1'b1;
      if (stall_after >= 0 && beats >= stall_after && stalls < stall_cycles) begin
        i_data_next = 1'b0;
        stalls++;
        if (stalls >= 2) begin
          #1;
          check("bp_src_next_low", 32'(o_src_next), 32'd0);
        end
      end
      step();
      if (join_now && !use_fix) begin
        i_src_data = $urandom;
        i_dst_data = $urandom;
      end
      n++;
    end
    i_data_next = 1'b1;
    i_src_valid = 1'b0;
    i_dst_valid = 1'b0;
    check("burst_in_budget", 32'(n < 2000), 32'd1);
    check("burst_done", 32'(o_done), 32'd1);
    check("burst_error", 32'(o_error), 32'd0);
    check("burst_beats", 32'(beats), 32'(len));
    check("burst_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_length = '0; i_mode = 2'b00;
    i_src_data = '0; i_dst_data = '0; i_src_valid = 1'b0; i_dst_valid = 1'b0;
    i_data_next = 1'b1; cur_mode = 2'b00;
    beats = 0; joins = 0; first_join_cyc = -1; first_valid_cyc = -1;
    step(); step();
    i_reset = 1'b0;
    #1;

    // Reset state.
    check("rst_data", o_data, 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_src_next", 32'(o_src_next), 32'd0);
    check("rst_dst_next", 32'(o_dst_next), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);

    // Copy, length 4, with pipeline latency.
    run_burst(2'b00, 4, 1'b0, 32'd0, 32'd0, -1, 0);
    check("copy_latency", 32'(first_valid_cyc - first_join_cyc), 32'd2);

    // Directed blend and saturating-add pixels.
    run_burst(2'b01, 1, 1'b1, 32'h80FF0000, 32'hFF0000FF, -1, 0);
    check("blend_pixel", last_out, 32'hFF80007F);
    run_burst(2'b10, 1, 1'b1, 32'h10F00010, 32'h10200020, -1, 0);
    check("add_pixel", last_out, 32'h20FF0030);

    // Blend stream with a 5-cycle downstream stall after the third beat.
    run_burst(2'b01, 8, 1'b0, 32'd0, 32'd0, 3, 5);
    run_burst(2'b10, 6, 1'b0, 32'd0, 32'd0, -1, 0);

    // Zero length goes straight to error.
    start_job(2'b00, '0);
    i_src_valid = 1'b1; i_dst_valid = 1'b1;
    check("len0_error", 32'(o_error), 32'd1);
    check("len0_done", 32'(o_done), 32'd0);
    check("len0_next", 32'(o_src_next), 32'd0);
    step(); step();
    check("len0_no_join", 32'(joins), 32'd0);
    check("len0_no_beat", 32'(beats), 32'd0);

    // Destination never valid: timeout after 256 stalled cycles in RUN.
    i_dst_valid = 1'b0;
    start_job(2'b00, LW'(4));
    for (int k = 0; k < 255; k++) step();
    check("to_error_before", 32'(o_error), 32'd0);
    step();
    check("to_error_at", 32'(o_error), 32'd1);
    check("to_no_join", 32'(joins), 32'd0);
    check("to_no_beat", 32'(beats), 32'd0);
    i_src_valid = 1'b0;

    // A fresh start recovers from error.
    run_burst(2'b00, 2, 1'b0, 32'd0, 32'd0, -1, 0);

    // Start during RUN is ignored; reset mid-burst flushes without a beat.
    start_job(2'b00, LW'(8));
    i_src_valid = 1'b1; i_dst_valid = 1'b1;
    i_src_data = $urandom; i_dst_data = $urandom;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        i_start = 1'b1; i_mode = 2'b11; i_length = '0;
      end
      step();
      i_start = 1'b0;
      if (join_now) begin
        i_src_data = $urandom;
        i_dst_data = $urandom;
      end
    end
    check("ign_start_error", 32'(o_error), 32'd0);
    check("ign_start_beats", 32'(beats), 32'd4);
    i_data_next = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    hold_pending = 1'b0;
    i_data_next = 1'b1;
    i_src_valid = 1'b0; i_dst_valid = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_data", o_data, 32'd0);
    check("mid_rst_next", 32'(o_src_next), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    exp_q.delete();
    beats = 0;
    step(); step();
    check("mid_rst_no_beat", 32'(beats), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_blend_stage.md
Name: painterengine_gpu_blend_stage

Overview:
- Consumes two 32-bit ARGB8888 pixel streams from the GPU DMA reader, one source channel and one destination channel, using the reader's data/valid/next handshake.
- Joins the two streams pixel by pixel and combines them as copy, alpha blend or saturating add.
- Emits the result as a data/valid/next stream toward the DMA writer.
- Counts pixels against a programmed length and reports done or error.

Parameters:
- LENGTH_WIDTH, 32, width of the pixel-count register.
- TIMEOUT, 256, number of consecutive stall cycles in RUN before the error state is entered.

Ports:
- i_wire_clock  in  1  single clock.
- i_wire_reset  in  1  synchronous, active-high reset.
- i_wire_start  in  1  one-cycle pulse; latches length and mode; ignored in RUN/DRAIN.
- i_wire_length  in  LENGTH_WIDTH  pixel count.
- i_wire_mode  in  2  00 copy, 01 alpha blend, 10 saturating add, 11 reserved.
- i_wire_src_data  in  32  source pixel from the reader.
- i_wire_src_valid  in  1  source valid.
- o_wire_src_next  out  1  source ready; drives the reader's next input.
- i_wire_dst_data  in  32  destination pixel from the reader.
- i_wire_dst_valid  in  1  destination valid.
- o_wire_dst_next  out  1  destination ready.
- o_wire_data  out  32  result pixel.
- o_wire_data_valid  out  1  result valid.
- i_wire_data_next  in  1  downstream ready.
- o_wire_done  out  1  sticky until the next start.
- o_wire_error  out  1  sticky until the next start.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, all counters 0.
  - o_wire_data=0, o_wire_data_valid=0, o_wire_src_next=0, o_wire_dst_next=0, o_wire_done=0, o_wire_error=0.
- Transfer rules:
  - A beat transfers on valid&&next.
  - A join fires when src_valid && dst_valid && accept, where accept = stage-1 empty, or the pipeline advances this cycle.
  - o_wire_src_next = o_wire_dst_next = accept && state==RUN && issued<length.
  - Both inputs are consumed in the same cycle; a single-side valid is never consumed.
- Pipeline:
  - Stage 1 registers the per-channel products.
  - Stage 2 registers the normalised result into o_wire_data.
  - Latency: join cycle N gives o_wire_data_valid at N+2 when there is no stall.
  - Advance = !o_wire_data_valid || i_wire_data_next.
  - On stall every stage holds. o_wire_data and o_wire_data_valid stay stable while valid&&!next.
  - Throughput: 1 pixel per cycle.
- Arithmetic, per 8-bit channel c with alpha a = src[31:24]:
  - Copy: out = src.
  - Blend: t = s*a + d*(255-a) + 128, 16 bits. c = (t + (t>>8)) >> 8, which is exact rounded /255.
  - Blend alpha channel: a_out = a + round(d_a*(255-a)/255), using the same formula.
  - Add: per channel min(s+d, 255), including alpha.
- State machine:
  - IDLE: on start, latch length/mode and clear done/error.
    - length==0 or mode==11 -> ERROR.
    - Otherwise -> RUN with issued=0, retired=0.
  - RUN:
    - issued increments per join.
    - retired increments per output beat accepted.
    - issued==length -> DRAIN.
    - TIMEOUT consecutive cycles with no join and no retire -> ERROR.
  - DRAIN: next deasserted; retired==length -> DONE. A drain stall also counts toward TIMEOUT -> ERROR.
  - DONE / ERROR: hold flags; start re-enters the IDLE start handling in the same cycle.
- Boundary conditions:
  - start during RUN/DRAIN is ignored.
  - Reset mid-burst flushes the pipeline with no output beat.
  - Join and retire in the same cycle both count.
  - Error entry clears o_wire_data_valid and discards in-flight pixels.
  - length = 2^LENGTH_WIDTH-1 must not wrap the counters.

Decomposition:
- Shared package holds:
  - State encodings (IDLE, RUN, DRAIN, DONE, ERROR).
  - Mode constants.
  - TIMEOUT default.
  - ARGB channel offset constants.
- One natural sub-module: painterengine_gpu_blend_channel, the combinational 8-bit channel combiner with mode, s, d and a inputs, instantiated 4×.

Test Plan:
- Copy, length=4, both streams always valid, next=1 -> out = src words in order. First valid 2 cycles after the first join. Done after the 4th beat.
- Blend, src=0x80FF0000, dst=0xFF0000FF, length=1 -> out=0xFF80007F.
- Add, src=0x10F00010, dst=0x10200020, length=1 -> out=0x20FF0030.
- Backpressure: data_next low for 5 cycles mid-stream -> output held stable, next deasserted, no pixel lost or duplicated over length=8.
- length=0 start -> error=1, done=0, no next asserted.
- dst_valid stuck low for 256 cycles in RUN -> error=1 and src is not consumed. A later start recovers.
